tab_table_loader: RTL and testbench

- Writer side of the tabulation-hash static table. It accepts a valid/ready stream of table entries and drives the table's synchronous write port sequentially from address 0 to Nloc-1.
- It tracks progress, accumulates an XOR checksum for load integrity, and flags completion. The hash datapath may then read the table asynchronously (entry at addr and at addr+1).
- Sits between the host/config interface and the table storage.

---
 rtl/tab_hash_pkg.sv | 24 ++
 rtl/tab_wr_stage.sv | 58 +++++
 rtl/tab_table_loader.sv | 157 +++++++++++++++
 tb/tb_tab_table_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tab_hash_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tab_hash_pkg
// Description : Shared definitions for the tabulation-hash table, its loader
//               and the hash datapath.
//               - Default table geometry, so every unit agrees on it.
//               - Loader FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package tab_hash_pkg;

  // Default table geometry.
  localparam int unsigned TAB_NLOC  = 256;
  localparam int unsigned TAB_DBITS = 32;

  // Loader FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_e;

endpackage : tab_hash_pkg
`default_nettype wire

// File: rtl/tab_wr_stage.sv
`default_nettype none
// ============================================================================
// Module      : tab_wr_stage
// Description : Registered table write port. It captures one write request
//               and presents it to the table storage on the next cycle.
//               Address and data hold between writes; only the enable
//               pulses.
// Ports       :
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   wr_i     in   write request this cycle
//   addr_i   in   [AW-1:0]  write address
//   data_i   in   [Dbits-1:0] write data
//   we_o     out  registered write enable
//   addr_o   out  registered write address
//   data_o   out  registered write data
// Revision    : 1.0 - initial release
// ============================================================================
module tab_wr_stage #(
  parameter int unsigned AW    = 8,
  parameter int unsigned Dbits = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [Dbits-1:0] data_i,
  output logic             we_o,
  output logic [AW-1:0]    addr_o,
  output logic [Dbits-1:0] data_o
);

  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [Dbits-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q <= wr_i;
      // Address and data are captured only on a write. The table sees
      // stable values when the enable is low.
      if (wr_i) begin
        addr_q <= addr_i;
        data_q <= data_i;
      end
    end
  end

  assign we_o   = we_q;
  assign addr_o = addr_q;
  assign data_o = data_q;

endmodule : tab_wr_stage
`default_nettype wire

// File: rtl/tab_table_loader.sv
`default_nettype none
// ============================================================================
// Module      : tab_table_loader
// Description : Writer side of the tabulation-hash static table. It accepts
//               a valid/ready stream of entries and writes them to addresses
//               0..Nloc-1 in order through a registered write port. It also
//               tracks progress, accumulates an XOR checksum and flags
//               completion.
// Ports       :
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   start         in   pulse; begins a fresh load at address 0
//   abort         in   pulse; cancels an in-progress load
//   s_valid       in   entry stream valid
//   s_data        in   [Dbits-1:0] entry value
//   s_ready       out  loader accepts an entry this cycle
//   tbl_we        out  table write enable (registered)
//   tbl_addr      out  [AW-1:0] table write address (registered)
//   tbl_wdata     out  [Dbits-1:0] table write data (registered)
//   busy          out  load in progress
//   done          out  sticky; the full table is loaded
//   loaded_count  out  [CW-1:0] entries accepted in the current/last load
//   checksum      out  [Dbits-1:0] XOR of the accepted entries
// Revision    : 1.0 - initial release
// ============================================================================
module tab_table_loader
  import tab_hash_pkg::*;
#(
  parameter  int unsigned Nloc  = TAB_NLOC,
  parameter  int unsigned Dbits = TAB_DBITS,
  localparam int unsigned AW    = $clog2(Nloc),
  localparam int unsigned CW    = $clog2(Nloc + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             s_valid,
  input  logic [Dbits-1:0] s_data,
  output logic             s_ready,
  output logic             tbl_we,
  output logic [AW-1:0]    tbl_addr,
  output logic [Dbits-1:0] tbl_wdata,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    loaded_count,
  output logic [Dbits-1:0] checksum
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(Nloc - 1);

  load_state_e      state_q, state_d;
  logic [AW-1:0]    ptr_q,   ptr_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [Dbits-1:0] csum_q,  csum_d;
  logic             done_q,  done_d;

  logic accept;
  logic at_last;

  // Abort masks ready combinationally. An entry presented in the abort
  // cycle is therefore never taken and never written.
  assign s_ready = (state_q == LOAD) && !abort;
  assign accept  = s_valid && s_ready;
  assign at_last = (ptr_q == LAST_ADDR);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      done_q  <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    done_d  = done_q;

    case (state_q)
      IDLE, DONE: begin
        // Abort is ignored here. Start begins a fresh load.
        if (start) begin
          state_d = LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
          csum_d  = '0;
          done_d  = 1'b0;
        end
      end

      LOAD: begin
        // Start is ignored while loading. Abort keeps the partial count
        // and checksum for inspection.
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          cnt_d  = cnt_q + CW'(1);
          csum_d = csum_q ^ s_data;
          if (at_last) begin
            // The pointer stays on the last address rather than wrapping.
            // done rises together with the final registered write.
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + AW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered write port: one table write per accepted entry, one cycle
  // later. The final write drains in the first DONE cycle.
  // --------------------------------------------------------------------------
  tab_wr_stage #(
    .AW    (AW),
    .Dbits (Dbits)
  ) u_wr_stage (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_i   (accept),
    .addr_i (ptr_q),
    .data_i (s_data),
    .we_o   (tbl_we),
    .addr_o (tbl_addr),
    .data_o (tbl_wdata)
  );

  assign busy         = (state_q == LOAD);
  assign done         = done_q;
  assign loaded_count = cnt_q;
  assign checksum     = csum_q;

endmodule : tab_table_loader
`default_nettype wire

// File: tb/tb_tab_table_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_tab_table_loader
// Description : Directed self-checking bench for tab_table_loader using
//               Nloc=4 and Dbits=32. The expected values are hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tab_table_loader;

  localparam int unsigned NLOC  = 4;
  localparam int unsigned DBITS = 32;
  localparam int unsigned AW    = 2;
  localparam int unsigned CW    = 3;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             start   = 1'b0;
  logic             abort   = 1'b0;
  logic             s_valid = 1'b0;
  logic [DBITS-1:0] s_data  = '0;

  logic             s_ready;
  logic             tbl_we;
  logic [AW-1:0]    tbl_addr;
  logic [DBITS-1:0] tbl_wdata;
  logic             busy;
  logic             done;
  logic [CW-1:0]    loaded_count;
  logic [DBITS-1:0] checksum;

  int errors = 0;
  int checks = 0;

  logic [DBITS-1:0] vals [NLOC];
  logic [DBITS-1:0] exp_csum;

  tab_table_loader #(
    .Nloc  (NLOC),
    .Dbits (DBITS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .tbl_we       (tbl_we),
    .tbl_addr     (tbl_addr),
    .tbl_wdata    (tbl_wdata),
    .busy         (busy),
    .done         (done),
    .loaded_count (loaded_count),
    .checksum     (checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue start from IDLE/DONE and check the cleared LOAD state.
  task automatic begin_load(input string pfx);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({pfx, ".busy"},  64'(busy), 64'd1);
    chk({pfx, ".done"},  64'(done), 64'd0);
    chk({pfx, ".cnt0"},  64'(loaded_count), 64'd0);
    chk({pfx, ".csum0"}, 64'(checksum), 64'd0);
  endtask

  // Stream vals[] back to back. When poke_start is set, start is also
  // raised during the second accept; it must have no effect.
  task automatic stream_vals(input string pfx, input bit poke_start);
    exp_csum = '0;
    for (int i = 0; i < int'(NLOC); i++) begin
      s_valid = 1'b1;
      s_data  = vals[i];
      if (poke_start && i == 1) start = 1'b1;
      chk($sformatf("%s.rdy%0d", pfx, i), 64'(s_ready), 64'd1);
      step();
      start    = 1'b0;
      exp_csum = exp_csum ^ vals[i];
      chk($sformatf("%s.we%0d", pfx, i),   64'(tbl_we), 64'd1);
      chk($sformatf("%s.addr%0d", pfx, i), 64'(tbl_addr), 64'(i));
      chk($sformatf("%s.data%0d", pfx, i), 64'(tbl_wdata), 64'(vals[i]));
      chk($sformatf("%s.cnt%0d", pfx, i),  64'(loaded_count), 64'(i + 1));
      chk($sformatf("%s.csum%0d", pfx, i), 64'(checksum), 64'(exp_csum));
      chk($sformatf("%s.done%0d", pfx, i), 64'(done), (i == int'(NLOC) - 1) ? 64'd1 : 64'd0);
    end
    chk({pfx, ".rdy_end"},  64'(s_ready), 64'd0);
    chk({pfx, ".busy_end"}, 64'(busy), 64'd0);
    step();
    s_valid = 1'b0;
    chk({pfx, ".we_drain"}, 64'(tbl_we), 64'd0);
    chk({pfx, ".done_hold"}, 64'(done), 64'd1);
  endtask

  initial begin
    // ---------------- Reset state ----------------
    #2;
    chk("rst.we",    64'(tbl_we), 64'd0);
    chk("rst.addr",  64'(tbl_addr), 64'd0);
    chk("rst.wdata", 64'(tbl_wdata), 64'd0);
    chk("rst.rdy",   64'(s_ready), 64'd0);
    chk("rst.busy",  64'(busy), 64'd0);
    chk("rst.done",  64'(done), 64'd0);
    chk("rst.cnt",   64'(loaded_count), 64'd0);
    chk("rst.csum",  64'(checksum), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("idle.rdy", 64'(s_ready), 64'd0);

    // ---------------- Full load ----------------
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h44; vals[3] = 32'h88;
    begin_load("full");
    stream_vals("full", 1'b0);
    chk("full.cnt",  64'(loaded_count), 64'd4);
    chk("full.csum", 64'(checksum), 64'hFF);

    // ---------------- Reload from DONE ----------------
    vals[0] = 32'h1; vals[1] = 32'h1; vals[2] = 32'h1; vals[3] = 32'h1;
    begin_load("reload");
    stream_vals("reload", 1'b0);
    chk("reload.cnt",  64'(loaded_count), 64'd4);
    chk("reload.csum", 64'(checksum), 64'h0);

    // ---------------- Gapped stream ----------------
    vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC; vals[3] = 32'hD;
    begin_load("gap");
    for (int i = 0; i < 8; i++) begin
      s_valid = (i % 2 == 0);
      s_data  = vals[i / 2];
      step();
      chk($sformatf("gap.we%0d", i),   64'(tbl_we), (i % 2 == 0) ? 64'd1 : 64'd0);
      chk($sformatf("gap.addr%0d", i), 64'(tbl_addr), 64'(i / 2));
      chk($sformatf("gap.data%0d", i), 64'(tbl_wdata), 64'(vals[i / 2]));
    end
    s_valid = 1'b0;
    chk("gap.done", 64'(done), 64'd1);
    chk("gap.cnt",  64'(loaded_count), 64'd4);
    chk("gap.csum", 64'(checksum), 64'h0);

    // ---------------- Abort ----------------
    vals[0] = 32'h5; vals[1] = 32'h6;
    begin_load("abort");
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data  = vals[i];
      step();
      chk($sformatf("abort.we%0d", i), 64'(tbl_we), 64'd1);
    end
    abort   = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'h7;
    #1;
    chk("abort.rdy_masked", 64'(s_ready), 64'd0);
    step();
    abort   = 1'b0;
    s_valid = 1'b0;
    chk("abort.we",   64'(tbl_we), 64'd0);
    chk("abort.addr", 64'(tbl_addr), 64'd1);
    chk("abort.data", 64'(tbl_wdata), 64'h6);
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.done", 64'(done), 64'd0);
    chk("abort.cnt",  64'(loaded_count), 64'd2);
    chk("abort.csum", 64'(checksum), 64'h3);
    step();
    chk("abort.idle_rdy", 64'(s_ready), 64'd0);

    // ---------------- Ignored controls ----------------
    vals[0] = 32'h10; vals[1] = 32'h20; vals[2] = 32'h30; vals[3] = 32'h40;
    begin_load("ign");
    stream_vals("ign", 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ign.done", 64'(done), 64'd1);
    chk("ign.busy", 64'(busy), 64'd0);
    chk("ign.cnt",  64'(loaded_count), 64'd4);
    chk("ign.csum", 64'(checksum), 64'h40);

    // ---------------- Async reset mid-load ----------------
    vals[0] = 32'h3; vals[1] = 32'h9;
    begin_load("arst");
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data  = vals[i];
      step();
    end
    chk("arst.we_pre", 64'(tbl_we), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.we",   64'(tbl_we), 64'd0);
    chk("arst.busy", 64'(busy), 64'd0);
    chk("arst.done", 64'(done), 64'd0);
    chk("arst.cnt",  64'(loaded_count), 64'd0);
    chk("arst.csum", 64'(checksum), 64'd0);
    chk("arst.rdy",  64'(s_ready), 64'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("arst.post_we%0d", i),  64'(tbl_we), 64'd0);
      chk($sformatf("arst.post_rdy%0d", i), 64'(s_ready), 64'd0);
    end
    s_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_tab_table_loader
`default_nettype wire
